// File: rtl/osr_autopull_pkg.sv
// Shared definitions for the output shift register and its sibling input
// shift register: data widths, operation selector and the count decode.
package osr_autopull_pkg;

    localparam int OSR_W     = 32;
    localparam int OSR_CNT_W = 6;

    // Which single operation owns the shift register on a given cycle.
    typedef enum logic [2:0] {
        OP_IDLE  = 3'd0,
        OP_MOV   = 3'd1,
        OP_PULL  = 3'd2,
        OP_AUTO  = 3'd3,
        OP_SHIFT = 3'd4
    } op_e;

    // Five-bit instruction count fields encode 32 as 0.
    function automatic logic [OSR_CNT_W-1:0] decode_count(input logic [4:0] v);
        if (v == 5'd0) begin
            decode_count = 6'd32;
        end else begin
            decode_count = {1'b0, v};
        end
    endfunction

endpackage

// File: rtl/osr_autopull_if.sv
// Bundle of the FIFO-side, instruction-side and result signals of the
// output shift register. The slave modport is the shift register itself.
interface osr_autopull_if;
    import osr_autopull_pkg::*;

    logic [OSR_W-1:0]     fifo_dout;
    logic                 fifo_empty;
    logic                 fifo_pull;
    logic                 shift_en;
    logic [4:0]           shift_bits;
    logic                 shift_right;
    logic                 pull_req;
    logic                 pull_block;
    logic [OSR_W-1:0]     x_in;
    logic                 mov_en;
    logic [OSR_W-1:0]     mov_din;
    logic                 autopull_en;
    logic [4:0]           pull_thresh;
    logic [OSR_W-1:0]     out_data;
    logic                 out_valid;
    logic                 stall;
    logic [OSR_CNT_W-1:0] osr_count;

    modport master (
        output fifo_dout, fifo_empty, shift_en, shift_bits, shift_right,
               pull_req, pull_block, x_in, mov_en, mov_din, autopull_en,
               pull_thresh,
        input  fifo_pull, out_data, out_valid, stall, osr_count
    );

    modport slave (
        input  fifo_dout, fifo_empty, shift_en, shift_bits, shift_right,
               pull_req, pull_block, x_in, mov_en, mov_din, autopull_en,
               pull_thresh,
        output fifo_pull, out_data, out_valid, stall, osr_count
    );

endinterface

// File: rtl/osr_autopull.sv
// Output shift register with explicit PULL, MOV and threshold-driven
// autopull from the TX FIFO. Results and the FIFO pop are combinational
// so an OUT or refill takes effect on the same clock edge.
module osr_autopull
    import osr_autopull_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    osr_autopull_if.slave  bus
);

    logic [OSR_W-1:0]     osr_r;
    logic [OSR_CNT_W-1:0] osr_count_r;

    logic [OSR_W-1:0]     osr_nxt_s;
    logic [OSR_CNT_W-1:0] cnt_nxt_s;
    logic [OSR_CNT_W:0]   cnt_sum_s;
    logic [OSR_CNT_W-1:0] n_s;
    logic [OSR_CNT_W-1:0] thresh_s;
    logic                 need_s;
    op_e                  op_s;

    logic [OSR_W-1:0]     out_data_s;
    logic                 out_valid_s;
    logic                 stall_s;
    logic                 fifo_pull_s;

    assign n_s      = decode_count(bus.shift_bits);
    assign thresh_s = decode_count(bus.pull_thresh);
    assign need_s   = bus.autopull_en && (osr_count_r >= thresh_s);

    assign bus.out_data  = out_data_s;
    assign bus.out_valid = out_valid_s;
    assign bus.stall     = stall_s;
    assign bus.fifo_pull = fifo_pull_s;
    assign bus.osr_count = osr_count_r;

    // Pick the single highest-priority operation; reset silences everything.
    always_comb begin
        op_s = OP_IDLE;
        if (reset) begin
            op_s = OP_IDLE;
        end else if (bus.mov_en) begin
            op_s = OP_MOV;
        end else if (bus.pull_req) begin
            op_s = OP_PULL;
        end else if (need_s) begin
            op_s = OP_AUTO;
        end else if (bus.shift_en) begin
            op_s = OP_SHIFT;
        end else begin
            op_s = OP_IDLE;
        end
    end

    // Execute the selected operation: next register state plus strobes.
    always_comb begin
        fifo_pull_s = 1'b0;
        out_valid_s = 1'b0;
        stall_s     = 1'b0;
        out_data_s  = 32'd0;
        osr_nxt_s   = osr_r;
        cnt_nxt_s   = osr_count_r;
        cnt_sum_s   = {1'b0, osr_count_r} + {1'b0, n_s};
        case (op_s)
            OP_MOV: begin
                osr_nxt_s = bus.mov_din;
                cnt_nxt_s = 6'd0;
            end
            OP_PULL: begin
                if (!bus.fifo_empty) begin
                    osr_nxt_s   = bus.fifo_dout;
                    cnt_nxt_s   = 6'd0;
                    fifo_pull_s = 1'b1;
                end else if (bus.pull_block) begin
                    stall_s = 1'b1;
                end else begin
                    osr_nxt_s = bus.x_in;
                    cnt_nxt_s = 6'd0;
                end
            end
            OP_AUTO: begin
                // An OUT presented while the register is exhausted always
                // waits a cycle, even when the refill lands right now.
                if (!bus.fifo_empty) begin
                    osr_nxt_s   = bus.fifo_dout;
                    cnt_nxt_s   = 6'd0;
                    fifo_pull_s = 1'b1;
                end else begin
                    osr_nxt_s = osr_r;
                end
                stall_s = bus.shift_en;
            end
            OP_SHIFT: begin
                out_valid_s = 1'b1;
                // Shift amounts of 32 fall out naturally as full-width
                // extraction and a zeroed register.
                if (bus.shift_right) begin
                    out_data_s = osr_r & ~(32'hFFFF_FFFF << n_s);
                    osr_nxt_s  = osr_r >> n_s;
                end else begin
                    out_data_s = osr_r >> (6'd32 - n_s);
                    osr_nxt_s  = osr_r << n_s;
                end
                if (cnt_sum_s > 7'd32) begin
                    cnt_nxt_s = 6'd32;
                end else begin
                    cnt_nxt_s = cnt_sum_s[OSR_CNT_W-1:0];
                end
            end
            default: begin
                osr_nxt_s = osr_r;
            end
        endcase
    end

    // Register update; reset leaves the register empty (count 32).
    always_ff @(posedge clk) begin
        if (reset) begin
            osr_r       <= 32'd0;
            osr_count_r <= 6'd32;
        end else begin
            osr_r       <= osr_nxt_s;
            osr_count_r <= cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_osr_autopull.sv
// Directed plus randomized bench for osr_autopull against an arithmetic
// reference model of the shift register.
module tb_osr_autopull;
    import osr_autopull_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    osr_autopull_if bus();

    osr_autopull dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int passed = 0;
    int fails = 0;

    bit [31:0] m_osr;
    int        m_cnt;
    bit [31:0] nx_osr;
    int        nx_cnt;

    logic [31:0] obs_data;
    logic        obs_valid, obs_stall, obs_pull;

    logic [31:0] exp41 [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: operations resolved by priority, shifts done as powers of two.
    task automatic model_eval(output logic [31:0] e_data, output logic e_valid,
                              output logic e_stall, output logic e_pull);
        int n, t;
        longint unsigned two, pw, v, word;
        two  = 64'd2;
        word = 64'd4294967296;
        e_data = 32'd0; e_valid = 1'b0; e_stall = 1'b0; e_pull = 1'b0;
        nx_osr = m_osr; nx_cnt = m_cnt;
        n = (bus.shift_bits == 5'd0) ? 32 : int'(bus.shift_bits);
        t = (bus.pull_thresh == 5'd0) ? 32 : int'(bus.pull_thresh);
        if (reset) begin
            nx_osr = 32'd0; nx_cnt = 32;
        end else if (bus.mov_en) begin
            nx_osr = bus.mov_din; nx_cnt = 0;
        end else if (bus.pull_req) begin
            if (!bus.fifo_empty) begin
                nx_osr = bus.fifo_dout; nx_cnt = 0; e_pull = 1'b1;
            end else if (bus.pull_block) begin
                e_stall = 1'b1;
            end else begin
                nx_osr = bus.x_in; nx_cnt = 0;
            end
        end else if (bus.autopull_en && m_cnt >= t) begin
            if (!bus.fifo_empty) begin
                nx_osr = bus.fifo_dout; nx_cnt = 0; e_pull = 1'b1;
            end
            e_stall = bus.shift_en;
        end else if (bus.shift_en) begin
            v = m_osr;
            pw = two ** n;
            e_valid = 1'b1;
            if (bus.shift_right) begin
                e_data = 32'(v % pw);
                nx_osr = 32'(v / pw);
            end else begin
                e_data = 32'(v / (two ** (32 - n)));
                nx_osr = 32'((v * pw) % word);
            end
            nx_cnt = (m_cnt + n > 32) ? 32 : m_cnt + n;
        end
    endtask

    // One clock: compare mid-cycle, then advance the model with the DUT.
    task automatic step(input string tag);
        logic [31:0] ed;
        logic ev, es, ep;
        #3;
        model_eval(ed, ev, es, ep);
        obs_data  = bus.out_data;
        obs_valid = bus.out_valid;
        obs_stall = bus.stall;
        obs_pull  = bus.fifo_pull;
        chk({tag, ".out_data"},  bus.out_data, ed);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
        chk({tag, ".stall"},     32'(bus.stall), 32'(es));
        chk({tag, ".fifo_pull"}, 32'(bus.fifo_pull), 32'(ep));
        chk({tag, ".osr_count"}, 32'(bus.osr_count), 32'(m_cnt));
        @(posedge clk);
        m_osr = nx_osr;
        m_cnt = nx_cnt;
        #1;
    endtask

    task automatic idle();
        bus.fifo_dout = 32'd0; bus.fifo_empty = 1'b1; bus.shift_en = 1'b0;
        bus.shift_bits = 5'd0; bus.shift_right = 1'b1; bus.pull_req = 1'b0;
        bus.pull_block = 1'b0; bus.x_in = 32'd0; bus.mov_en = 1'b0;
        bus.mov_din = 32'd0; bus.autopull_en = 1'b0; bus.pull_thresh = 5'd0;
    endtask

    initial begin
        exp41[0] = 32'h0000_00EF; exp41[1] = 32'h0000_00BE;
        exp41[2] = 32'h0000_00AD; exp41[3] = 32'h0000_00DE;
        m_osr = 32'd0; m_cnt = 32;
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        step("reset0");
        step("reset1");
        chk("reset_count", 32'(bus.osr_count), 32'd32);
        reset = 1'b0;

        // First refill right after reset.
        bus.autopull_en = 1'b1; bus.pull_thresh = 5'd0;
        bus.fifo_empty = 1'b0; bus.fifo_dout = 32'hDEAD_BEEF;
        step("first_refill");
        chk("first_refill_pull", 32'(obs_pull), 32'd1);
        chk("first_refill_count", 32'(bus.osr_count), 32'd0);
        bus.fifo_empty = 1'b1;

        // Four right shifts of 8.
        bus.shift_en = 1'b1; bus.shift_bits = 5'd8; bus.shift_right = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("rshift8");
            chk("rshift8_data", obs_data, exp41[i]);
            chk("rshift8_count", 32'(bus.osr_count), 32'(8 * (i + 1)));
        end

        // Left shifts of 1 and 32.
        bus.autopull_en = 1'b0; bus.shift_en = 1'b0;
        bus.mov_en = 1'b1; bus.mov_din = 32'h8000_0001;
        step("mov");
        bus.mov_en = 1'b0;
        bus.shift_en = 1'b1; bus.shift_right = 1'b0; bus.shift_bits = 5'd1;
        step("lshift1");
        chk("lshift1_data", obs_data, 32'd1);
        bus.shift_bits = 5'd0;
        step("lshift32");
        chk("lshift32_data", obs_data, 32'd2);
        bus.shift_right = 1'b1;
        step("after_lshift32");
        chk("osr_zero", obs_data, 32'd0);

        // Autopull stall on empty FIFO, then refill and retry.
        bus.autopull_en = 1'b1; bus.shift_bits = 5'd8;
        for (int i = 0; i < 3; i++) begin
            step("ap_stall");
            chk("ap_stall_flag", 32'(obs_stall), 32'd1);
        end
        bus.fifo_empty = 1'b0; bus.fifo_dout = 32'hA5A5_1234;
        step("ap_refill");
        chk("ap_refill_pull", 32'(obs_pull), 32'd1);
        chk("ap_refill_stall", 32'(obs_stall), 32'd1);
        bus.fifo_empty = 1'b1;
        step("ap_retry");
        chk("ap_retry_valid", 32'(obs_valid), 32'd1);
        chk("ap_retry_data", obs_data, 32'h34);

        // Blocking and non-blocking PULL on an empty FIFO.
        bus.autopull_en = 1'b0; bus.shift_en = 1'b0;
        bus.pull_req = 1'b1; bus.pull_block = 1'b1;
        step("pull_block");
        chk("pull_block_stall", 32'(obs_stall), 32'd1);
        bus.pull_req = 1'b0; bus.shift_en = 1'b1;
        step("pull_block_keep");
        chk("pull_block_keep_data", obs_data, 32'h12);
        bus.shift_en = 1'b0; bus.pull_req = 1'b1; bus.pull_block = 1'b0;
        bus.x_in = 32'h1234_5678;
        step("pull_nb");
        chk("pull_nb_stall", 32'(obs_stall), 32'd0);
        bus.pull_req = 1'b0; bus.shift_en = 1'b1; bus.shift_bits = 5'd0;
        step("pull_nb_read");
        chk("pull_nb_data", obs_data, 32'h1234_5678);

        // MOV beats PULL.
        bus.shift_en = 1'b0; bus.mov_en = 1'b1; bus.pull_req = 1'b1;
        bus.fifo_empty = 1'b0; bus.fifo_dout = 32'hCAFE_F00D;
        bus.mov_din = 32'h0BAD_C0DE;
        step("mov_vs_pull");
        chk("mov_vs_pull_pull", 32'(obs_pull), 32'd0);
        bus.mov_en = 1'b0; bus.pull_req = 1'b0; bus.fifo_empty = 1'b1;
        bus.shift_en = 1'b1;
        step("mov_vs_pull_read");
        chk("mov_vs_pull_data", obs_data, 32'h0BAD_C0DE);

        // Reset during a stall drops the OUT.
        bus.autopull_en = 1'b1;
        step("pre_reset_stall");
        chk("pre_reset_stall_flag", 32'(obs_stall), 32'd1);
        reset = 1'b1;
        step("reset_mid_stall");
        chk("reset_mid_stall_flag", 32'(obs_stall), 32'd0);
        reset = 1'b0; bus.shift_en = 1'b0;
        chk("reset_mid_stall_count", 32'(bus.osr_count), 32'd32);
        bus.fifo_empty = 1'b0; bus.fifo_dout = 32'h0000_0055;
        step("refill_after_reset");
        chk("refill_after_reset_pull", 32'(obs_pull), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            reset           = ($urandom_range(0, 99) == 0);
            bus.mov_en      = ($urandom_range(0, 15) == 0);
            bus.pull_req    = ($urandom_range(0, 9) == 0);
            bus.pull_block  = 1'($urandom);
            bus.fifo_empty  = 1'($urandom);
            bus.fifo_dout   = $urandom;
            bus.shift_en    = ($urandom_range(0, 2) != 0);
            bus.shift_bits  = 5'($urandom_range(0, 31));
            bus.shift_right = 1'($urandom);
            bus.autopull_en = ($urandom_range(0, 3) != 0);
            bus.pull_thresh = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.x_in        = $urandom;
            bus.mov_din     = $urandom;
            step("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/osr_autopull.md
OSR_AUTOPULL -- requirements
Module: osr_autopull

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 fifo_dout  in  32  TX FIFO head word, valid when fifo_empty=0.
REQ-005 fifo_empty  in  1  TX FIFO empty flag.
REQ-006 fifo_pull  out  1  combinational pop strobe to the TX FIFO; pops on the same posedge.
REQ-007 shift_en  in  1  OUT instruction request.
REQ-008 shift_bits  in  5  OUT bit count; 0 means 32.
REQ-009 shift_right  in  1  1 = shift toward LSB, 0 = shift toward MSB.
REQ-010 pull_req  in  1  explicit PULL instruction request.
REQ-011 pull_block  in  1  1 = blocking PULL, 0 = non-blocking PULL.
REQ-012 x_in  in  32  scratch X value; loaded on a non-blocking PULL from an empty FIFO.
REQ-013 mov_en / mov_din  in  1 / 32  direct OSR write (MOV OSR).
REQ-014 autopull_en  in  1  autopull enable.
REQ-015 pull_thresh  in  5  autopull threshold in bits; 0 means 32.
REQ-016 out_data  out  32  shifted-out bits, right-aligned and zero-extended; combinational.
REQ-017 out_valid  out  1  an OUT completes on this cycle.
REQ-018 stall  out  1  the requesting instruction did not complete; it must be re-presented.
REQ-019 osr_count  out  6  bits consumed since the last load, range 0..32.

Function
REQ-020 Definitions: n = shift_bits with 0 mapped to 32; T = pull_thresh with 0 mapped to 32; need = autopull_en && osr_count >= T.
REQ-021 Per-cycle priority SHALL be mov_en, then pull_req, then autopull refill, then shift_en; the highest-priority active operation is the only one to act.
REQ-022 mov_en: osr <= mov_din, osr_count <= 0, fifo_pull = 0; a concurrent pull_req or shift_en is ignored and stall = 0.
REQ-023 pull_req with fifo_empty=0: osr <= fifo_dout, osr_count <= 0, fifo_pull = 1, stall = 0.
REQ-024 pull_req with fifo_empty=1 and pull_block=1: no state change, stall = 1.
REQ-025 pull_req with fifo_empty=1 and pull_block=0: osr <= x_in, osr_count <= 0, stall = 0.
REQ-026 Autopull refill: when need && !fifo_empty and no mov/pull is active, osr <= fifo_dout, osr_count <= 0, fifo_pull = 1; this happens even when shift_en = 0.
REQ-027 shift_en while need: the OUT is not executed, stall = 1, out_valid = 0.
- A refill in the same cycle makes the retried OUT complete on the next cycle (1-cycle stall).
- If the FIFO is empty, the stall persists until data arrives.
REQ-028 shift_en while !need, right shift: out_data = osr[n-1:0]; osr <= osr >> n.
REQ-029 shift_en while !need, left shift: out_data = osr[31:32-n]; osr <= osr << n.
REQ-030 On a completed OUT: out_valid = 1, and osr_count <= min(osr_count + n, 32), saturating at 32.
REQ-031 A shift by 32 in either direction SHALL leave osr = 0.
REQ-032 out_data SHALL be 0 whenever out_valid = 0.
REQ-033 fifo_pull SHALL never assert while fifo_empty = 1, and SHALL assert at most once per cycle.
REQ-034 stall SHALL be 0 whenever neither pull_req nor shift_en is asserted.

Reset
REQ-035 On reset: osr = 0, osr_count = 32 (empty), fifo_pull = 0, out_valid = 0, stall = 0, out_data = 0.
REQ-036 Reset asserted mid-stall SHALL clear all state; the aborted instruction is dropped.
REQ-037 With autopull_en = 1 and the FIFO non-empty, the first refill SHALL occur on the first cycle after reset deasserts.

Structure
REQ-038 A shared package SHALL hold OSR_W = 32, OSR_CNT_W = 6, and the "0 means 32" count-decode function, which is shared with the ISR block.
REQ-039 The block SHALL be a single module with no sub-modules; the shifter is inline combinational logic.

Verification
REQ-040 Reset, then autopull_en = 1, T = 32, FIFO holds 0xDEADBEEF -> fifo_pull = 1 on the first cycle, then osr_count = 0.
REQ-041 OSR = 0xDEADBEEF, right shifts of 8 four times -> out_data = 0xEF, 0xBE, 0xAD, 0xDE; osr_count = 8, 16, 24, 32.
REQ-042 OSR = 0x80000001, left shift n = 1 -> out_data = 1, osr = 0x00000002; then shift_bits = 0 -> out_data = 0x00000002, osr = 0.
REQ-043 osr_count = 32, autopull on, FIFO empty for 3 cycles, shift_en held -> stall = 1 for 3 cycles; word arrives -> refill, then OUT completes on the next cycle.
REQ-044 pull_req with FIFO empty: pull_block = 1 -> stall = 1 and osr unchanged; pull_block = 0 with x_in = 0x12345678 -> osr = 0x12345678, stall = 0.
REQ-045 mov_en and pull_req in the same cycle, FIFO non-empty -> osr = mov_din, fifo_pull = 0.
